// File: rtl/ysyx_24100005_lsu_pkg.sv
// Shared constants and types for the load/store unit: RISC-V funct3 codes,
// FSM state encoding and per-size byte-lane masks.
package ysyx_24100005_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } lsu_state_e;

    // Byte-lane mask for an access size code (funct3[1:0]).
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] m;
        unique case (size)
            2'd0:    m = MASK_B;
            2'd1:    m = MASK_H;
            2'd2:    m = MASK_W;
            default: m = MASK_D;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ysyx_24100005_lsu_if.sv
// Core request, memory bus and response signals of the LSU in one bundle.
// slave is the LSU's view; master is the surrounding core/memory view.
interface ysyx_24100005_lsu_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_W-1:0]     req_addr;
    logic [XLEN-1:0]       req_wdata;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [XLEN-1:0]       mem_wdata;
    logic [XLEN/8-1:0]     mem_wmask;
    logic                  mem_resp_valid;
    logic [XLEN-1:0]       mem_resp_rdata;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [XLEN-1:0]       resp_rdata;
    logic                  resp_err;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata, resp_ready,
        output req_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        output resp_valid, resp_rdata, resp_err
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata, resp_ready,
        input  req_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/ysyx_24100005_lsu_align.sv
// Combinational access decode: legality, store lane placement and load
// lane extraction with sign/zero extension.
module ysyx_24100005_lsu_align
    import ysyx_24100005_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic              we_i,
    input  logic [2:0]        funct3_i,
    input  logic [2:0]        off_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   rdata_i,
    output logic              legal_c,
    output logic [XLEN/8-1:0] wmask_c,
    output logic [XLEN-1:0]   wdata_c,
    output logic [XLEN-1:0]   rdata_c
);
    localparam int unsigned NB           = XLEN / 8;
    localparam logic [2:0]  MAX_STORE_F3 = (XLEN == 64) ? F3_SD : F3_SW;

    logic [1:0]      size;
    logic [5:0]      shamt;
    logic [XLEN-1:0] bit_en;
    logic [XLEN-1:0] rsh;

    assign size  = funct3_i[1:0];
    assign shamt = {off_i, 3'b000};

    // Legality: unsupported encodings for this XLEN, then natural alignment.
    always_comb begin
        legal_c = 1'b1;
        if (we_i) begin
            if (funct3_i > MAX_STORE_F3) legal_c = 1'b0;
        end else begin
            if (funct3_i == 3'b111) legal_c = 1'b0;
            if ((XLEN == 32) && ((funct3_i == F3_LD) || (funct3_i == F3_LWU))) legal_c = 1'b0;
        end
        unique case (size)
            2'd1:    if (off_i[0])        legal_c = 1'b0;
            2'd2:    if (|off_i[1:0])     legal_c = 1'b0;
            2'd3:    if (|off_i)          legal_c = 1'b0;
            default: ;
        endcase
    end

    always_comb begin
        wmask_c = '0;
        if (we_i && legal_c) wmask_c = NB'({8'h00, size_mask(size)} << off_i);
        bit_en = '0;
        for (int i = 0; i < int'(NB); i++) bit_en[8*i +: 8] = {8{wmask_c[i]}};
        wdata_c = (wdata_i << shamt) & bit_en;
    end

    // Load lanes are moved down to bit 0 before extension.
    always_comb begin
        rsh = rdata_i >> shamt;
        unique case (funct3_i)
            F3_LB:   rdata_c = XLEN'($signed(rsh[7:0]));
            F3_LH:   rdata_c = XLEN'($signed(rsh[15:0]));
            F3_LW:   rdata_c = XLEN'($signed(rsh[31:0]));
            F3_LD:   rdata_c = rsh;
            F3_LBU:  rdata_c = XLEN'(rsh[7:0]);
            F3_LHU:  rdata_c = XLEN'(rsh[15:0]);
            F3_LWU:  rdata_c = XLEN'(rsh[31:0]);
            default: rdata_c = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_24100005_lsu.sv
// Single-outstanding load/store unit: accepts one core request, performs one
// aligned memory transaction and returns a registered, extended response.
module ysyx_24100005_lsu
    import ysyx_24100005_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    ysyx_24100005_lsu_if.slave bus
);
    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [2:0]        off_q, off_d;

    logic              req_ready_q, req_ready_d;
    logic              mem_req_valid_q, mem_req_valid_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [NB-1:0]     mem_wmask_q, mem_wmask_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic              al_we;
    logic [2:0]        al_f3;
    logic [2:0]        al_off;
    logic              al_legal;
    logic [NB-1:0]     al_wmask;
    logic [XLEN-1:0]   al_wdata;
    logic [XLEN-1:0]   al_rdata;

    // The decoder sees the live request in IDLE and the captured one afterwards.
    always_comb begin
        if (state_q == S_IDLE) begin
            al_we  = bus.req_we;
            al_f3  = bus.req_funct3;
            al_off = 3'(bus.req_addr[OFF_W-1:0]);
        end else begin
            al_we  = we_q;
            al_f3  = funct3_q;
            al_off = off_q;
        end
    end

    ysyx_24100005_lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .we_i     (al_we),
        .funct3_i (al_f3),
        .off_i    (al_off),
        .wdata_i  (bus.req_wdata),
        .rdata_i  (bus.mem_resp_rdata),
        .legal_c  (al_legal),
        .wmask_c  (al_wmask),
        .wdata_c  (al_wdata),
        .rdata_c  (al_rdata)
    );

    always_comb begin
        state_d         = state_q;
        we_d            = we_q;
        funct3_d        = funct3_q;
        off_d           = off_q;
        req_ready_d     = req_ready_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_wmask_d     = mem_wmask_q;
        resp_valid_d    = resp_valid_q;
        resp_rdata_d    = resp_rdata_q;
        resp_err_d      = resp_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    we_d        = bus.req_we;
                    funct3_d    = bus.req_funct3;
                    off_d       = al_off;
                    req_ready_d = 1'b0;
                    if (al_legal) begin
                        state_d         = S_REQ;
                        mem_req_valid_d = 1'b1;
                        mem_we_d        = bus.req_we;
                        mem_addr_d      = {bus.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                        mem_wdata_d     = al_wdata;
                        mem_wmask_d     = al_wmask;
                    end else begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end
                end
            end
            S_REQ: begin
                if (bus.mem_req_ready) begin
                    state_d         = S_WAIT;
                    mem_req_valid_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (bus.mem_resp_valid) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = we_q ? '0 : al_rdata;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            we_q            <= 1'b0;
            funct3_q        <= '0;
            off_q           <= '0;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_wmask_q     <= '0;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= '0;
            resp_err_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            we_q            <= we_d;
            funct3_q        <= funct3_d;
            off_q           <= off_d;
            req_ready_q     <= req_ready_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_wmask_q     <= mem_wmask_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_err_q      <= resp_err_d;
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.mem_wmask     = mem_wmask_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_rdata    = resp_rdata_q;
    assign bus.resp_err      = resp_err_q;

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Directed bench for the LSU (XLEN=32): loads, stores, illegal accesses,
// back-pressure on both sides and reset aborts.
module tb_ysyx_24100005_lsu;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   mem_hs   = 0;

    ysyx_24100005_lsu_if #(.XLEN(32), .ADDR_W(32)) bus ();

    ysyx_24100005_lsu #(.XLEN(32), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_req_valid && bus.mem_req_ready) mem_hs <= mem_hs + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One full request/response exchange with optional stalls on both sides.
    task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input logic legal,
                       input logic [31:0] e_maddr, input logic [31:0] e_wdata,
                       input logic [3:0] e_wmask, input logic [31:0] e_rdata,
                       input int stall_mem, input int stall_resp);
        int hs_cyc;
        int hs0;
        @(negedge clk);
        chk({tag, ":req_ready"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        hs_cyc = cyc;
        hs0    = mem_hs;
        @(negedge clk);
        chk({tag, ":req_ready_busy"}, 64'(bus.req_ready), 64'd0);
        if (legal) begin
            chk({tag, ":mem_req_valid"}, 64'(bus.mem_req_valid), 64'd1);
            chk({tag, ":mem_we"},        64'(bus.mem_we),        64'(we));
            chk({tag, ":mem_addr"},      64'(bus.mem_addr),      64'(e_maddr));
            chk({tag, ":mem_wdata"},     64'(bus.mem_wdata),     64'(e_wdata));
            chk({tag, ":mem_wmask"},     64'(bus.mem_wmask),     64'(e_wmask));
            for (int i = 0; i < stall_mem; i++) begin
                bus.mem_resp_valid = (i == 0);
                @(negedge clk);
                chk({tag, ":stall_valid"},   64'(bus.mem_req_valid), 64'd1);
                chk({tag, ":stall_addr"},    64'(bus.mem_addr),      64'(e_maddr));
                chk({tag, ":stall_wdata"},   64'(bus.mem_wdata),     64'(e_wdata));
                chk({tag, ":stall_wmask"},   64'(bus.mem_wmask),     64'(e_wmask));
                chk({tag, ":stall_no_resp"}, 64'(bus.resp_valid),    64'd0);
            end
            bus.mem_resp_valid = 1'b0;
            bus.mem_req_ready  = 1'b1;
            @(posedge clk); #1;
            bus.mem_req_ready = 1'b0;
            @(negedge clk);
            chk({tag, ":mem_req_drop"}, 64'(bus.mem_req_valid), 64'd0);
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_rdata = rdata;
            @(posedge clk); #1;
            bus.mem_resp_valid = 1'b0;
            @(negedge clk);
        end else begin
            chk({tag, ":no_mem_req"}, 64'(bus.mem_req_valid), 64'd0);
        end
        chk({tag, ":resp_valid"}, 64'(bus.resp_valid), 64'd1);
        chk({tag, ":resp_err"},   64'(bus.resp_err),   64'(!legal));
        chk({tag, ":resp_rdata"}, 64'(bus.resp_rdata), 64'(e_rdata));
        chk({tag, ":latency"},    64'(cyc - hs_cyc),   legal ? 64'(2 + stall_mem) : 64'd0);
        chk({tag, ":mem_hs"},     64'(mem_hs - hs0),   legal ? 64'd1 : 64'd0);
        for (int i = 0; i < stall_resp; i++) begin
            @(negedge clk);
            chk({tag, ":hold_valid"}, 64'(bus.resp_valid), 64'd1);
            chk({tag, ":hold_rdata"}, 64'(bus.resp_rdata), 64'(e_rdata));
            chk({tag, ":hold_err"},   64'(bus.resp_err),   64'(!legal));
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        chk({tag, ":resp_done"}, 64'(bus.resp_valid), 64'd0);
        chk({tag, ":idle_ready"}, 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        rst                = 1'b1;
        bus.req_valid      = 1'b0;
        bus.req_we         = 1'b0;
        bus.req_funct3     = 3'd0;
        bus.req_addr       = 32'd0;
        bus.req_wdata      = 32'd0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = 32'd0;
        bus.resp_ready     = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst:req_ready",     64'(bus.req_ready),     64'd1);
        chk("rst:mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        chk("rst:mem_we",        64'(bus.mem_we),        64'd0);
        chk("rst:mem_addr",      64'(bus.mem_addr),      64'd0);
        chk("rst:mem_wdata",     64'(bus.mem_wdata),     64'd0);
        chk("rst:mem_wmask",     64'(bus.mem_wmask),     64'd0);
        chk("rst:resp_valid",    64'(bus.resp_valid),    64'd0);
        chk("rst:resp_rdata",    64'(bus.resp_rdata),    64'd0);
        chk("rst:resp_err",      64'(bus.resp_err),      64'd0);

        //   tag     we    f3    addr          wdata         rdata         legal maddr         wdata         wmask  rdata         stall
        txn("lw",    1'b0, 3'd2, 32'h8000_0004, 32'h0,        32'hDEAD_BEEF, 1'b1, 32'h8000_0004, 32'h0,        4'h0, 32'hDEAD_BEEF, 0, 0);
        txn("lb",    1'b0, 3'd0, 32'h8000_0003, 32'h0,        32'h80FF_1234, 1'b1, 32'h8000_0000, 32'h0,        4'h0, 32'hFFFF_FF80, 0, 0);
        txn("lbu",   1'b0, 3'd4, 32'h8000_0003, 32'h0,        32'h80FF_1234, 1'b1, 32'h8000_0000, 32'h0,        4'h0, 32'h0000_0080, 0, 0);
        txn("lh",    1'b0, 3'd1, 32'h8000_0002, 32'h0,        32'h80FF_1234, 1'b1, 32'h8000_0000, 32'h0,        4'h0, 32'hFFFF_80FF, 0, 0);
        txn("lhu",   1'b0, 3'd5, 32'h8000_0002, 32'h0,        32'h80FF_1234, 1'b1, 32'h8000_0000, 32'h0,        4'h0, 32'h0000_80FF, 0, 0);
        txn("lb_pos",1'b0, 3'd0, 32'h8000_0000, 32'h0,        32'h1234_567F, 1'b1, 32'h8000_0000, 32'h0,        4'h0, 32'h0000_007F, 0, 0);
        txn("sh",    1'b1, 3'd1, 32'h8000_0002, 32'h0000_ABCD, 32'h1111_1111, 1'b1, 32'h8000_0000, 32'hABCD_0000, 4'hC, 32'h0,        0, 0);
        txn("sw",    1'b1, 3'd2, 32'h8000_0008, 32'hCAFE_F00D, 32'h2222_2222, 1'b1, 32'h8000_0008, 32'hCAFE_F00D, 4'hF, 32'h0,        0, 0);
        txn("sb_stl",1'b1, 3'd0, 32'h8000_0001, 32'h1234_5678, 32'h3333_3333, 1'b1, 32'h8000_0000, 32'h0000_7800, 4'h2, 32'h0,        5, 3);
        txn("lw_mis",1'b0, 3'd2, 32'h8000_0002, 32'h0,        32'h0,         1'b0, 32'h0,         32'h0,        4'h0, 32'h0,        0, 0);
        txn("lh_mis",1'b0, 3'd1, 32'h8000_0001, 32'h0,        32'h0,         1'b0, 32'h0,         32'h0,        4'h0, 32'h0,        0, 2);
        txn("ld_32", 1'b0, 3'd3, 32'h8000_0000, 32'h0,        32'h0,         1'b0, 32'h0,         32'h0,        4'h0, 32'h0,        0, 0);
        txn("lwu_32",1'b0, 3'd6, 32'h8000_0000, 32'h0,        32'h0,         1'b0, 32'h0,         32'h0,        4'h0, 32'h0,        0, 0);
        txn("sd_32", 1'b1, 3'd3, 32'h8000_0000, 32'h1,        32'h0,         1'b0, 32'h0,         32'h0,        4'h0, 32'h0,        0, 0);
        txn("s_f3_4",1'b1, 3'd4, 32'h8000_0000, 32'h1,        32'h0,         1'b0, 32'h0,         32'h0,        4'h0, 32'h0,        0, 0);

        // Reset while a request is still waiting for mem_req_ready.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd2;
        bus.req_addr = 32'h8000_0010; bus.req_wdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rreq:mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
        rst = 1'b1; #1;
        chk("rreq:mem_req_drop", 64'(bus.mem_req_valid), 64'd0);
        chk("rreq:mem_wmask",    64'(bus.mem_wmask),     64'd0);
        chk("rreq:mem_wdata",    64'(bus.mem_wdata),     64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in WAIT followed by a stale memory response.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2;
        bus.req_addr = 32'h8000_0000; bus.req_wdata = 32'h0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        bus.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        chk("rwait:mem_addr_pre", 64'(bus.mem_addr), 64'h8000_0000);
        rst = 1'b1; #1;
        chk("rwait:mem_addr",   64'(bus.mem_addr),      64'd0);
        chk("rwait:mem_valid",  64'(bus.mem_req_valid), 64'd0);
        chk("rwait:resp_valid", 64'(bus.resp_valid),    64'd0);
        chk("rwait:mem_we",     64'(bus.mem_we),        64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        bus.mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("stale:resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("stale:resp_rdata", 64'(bus.resp_rdata), 64'd0);
        chk("stale:req_ready",  64'(bus.req_ready),  64'd1);
        txn("lw_post", 1'b0, 3'd2, 32'h8000_0000, 32'h0, 32'h1357_9BDF, 1'b1, 32'h8000_0000, 32'h0, 4'h0, 32'h1357_9BDF, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_24100005_lsu.md
YSYX_24100005_LSU -- requirements
Module: ysyx_24100005_lsu

Interface
REQ-001 Parameter XLEN, 32, data width in bits (32 or 64) SHALL be supported.
REQ-002 Parameter ADDR_W, 32, address width in bits.
REQ-003 Port clk  in  1  single clock; all state on rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-high.
REQ-005 Port req_valid  in  1  core issues load/store.
REQ-006 Port req_ready  out  1  LSU accepts a request.
REQ-007 Port req_we  in  1  1=store, 0=load.
REQ-008 Port req_funct3  in  3  RV size/sign code (lb/lh/lw/ld/lbu/lhu/lwu; sb/sh/sw/sd).
REQ-009 Port req_addr  in  ADDR_W  byte address; req_wdata  in  XLEN  store data (low bytes).
REQ-010 Port mem_req_valid  out  1; mem_req_ready  in  1; mem_we  out  1.
REQ-011 Port mem_addr  out  ADDR_W  XLEN/8-aligned; mem_wdata  out  XLEN; mem_wmask  out  XLEN/8.
REQ-012 Port mem_resp_valid  in  1  read data / write ack; mem_resp_rdata  in  XLEN.
REQ-013 Port resp_valid  out  1; resp_ready  in  1; resp_rdata  out  XLEN; resp_err  out  1 (misaligned or illegal funct3).

Function
REQ-014 FSM states IDLE, REQ, WAIT, RESP SHALL be implemented.
REQ-015 req_ready SHALL be 1 only in IDLE; handshake = req_valid && req_ready; request fields captured on handshake.
REQ-016 IDLE -> REQ on handshake if legal; IDLE -> RESP with resp_err=1 if illegal; no mem request issued for illegal.
REQ-017 Illegal: half with addr[0]=1; word with addr[1:0]!=0; double with addr[2:0]!=0; double or lwu when XLEN=32; store funct3 > size code of XLEN.
REQ-018 REQ: mem_req_valid=1, mem_addr = addr with low log2(XLEN/8) bits cleared, mem_we/mem_wdata/mem_wmask held stable until mem_req_ready; REQ -> WAIT on mem handshake.
REQ-019 Store: mem_wdata = store data shifted left by 8*offset, unused lanes 0; mem_wmask = size mask (1,3,F,FF) shifted by offset.
REQ-020 Load: mem_wmask = 0, mem_wdata = 0.
REQ-021 WAIT -> RESP on mem_resp_valid; load result = mem_resp_rdata shifted right by 8*offset, sign- or zero-extended per funct3 to XLEN, registered into resp_rdata; store resp_rdata = 0.
REQ-022 RESP: resp_valid=1, resp_rdata/resp_err stable until resp_ready; RESP -> IDLE on resp handshake.
REQ-023 mem_resp_valid outside WAIT SHALL be ignored.
REQ-024 Minimum latency: handshake cycle N, mem_req_valid at N+1, mem_resp_valid earliest N+2, resp_valid at N+3; illegal request: resp_valid at N+1.
REQ-025 Exactly one mem handshake per legal request; none per illegal request.
REQ-026 New request accepted no earlier than the cycle after resp handshake (no overlap).

Reset
REQ-027 rst SHALL force IDLE immediately (asynchronously), including mid-REQ/WAIT/RESP.
REQ-028 Reset values: req_ready=1 after release, all other outputs 0; captured fields cleared.
REQ-029 A memory response for a request aborted by reset SHALL be dropped.

Structure
REQ-030 Package ysyx_24100005_pkg SHALL hold funct3 load/store constants, state enum, size-mask constants.
REQ-031 Combinational sub-module ysyx_24100005_lsu_align SHALL compute legality, wmask, shifted wdata, and extracted/extended load data; FSM and registers stay in the top-level LSU.

Verification
REQ-032 lw 0x8000_0004, mem returns 0xDEADBEEF -> mem_addr 0x8000_0004, wmask 0x0, resp_rdata 0xDEADBEEF, err 0, resp_valid 3 cycles after accept.
REQ-033 lb 0x8000_0003 with mem word 0x80FF_1234 -> resp_rdata 0xFFFF_FF80; lbu same -> 0x0000_0080; lh 0x8000_0002 -> 0xFFFF_80FF.
REQ-034 sh 0x8000_0002 wdata 0x0000_ABCD -> mem_wdata 0xABCD_0000, mem_wmask 4'b1100, mem_addr 0x8000_0000, resp_rdata 0.
REQ-035 lw 0x8000_0002 -> resp_err 1, resp_valid next cycle, mem_req_valid never 1.
REQ-036 mem_req_ready low 5 cycles, then resp_ready low 3 cycles -> mem outputs and resp outputs stable throughout, one mem handshake.
REQ-037 rst pulsed in WAIT, stale mem_resp_valid next cycle -> outputs 0 immediately, stale response ignored, following lw 0x8000_0000 returns correct data (XLEN=64 run: ld 0x8000_0008 returns full 64-bit word).
